// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and controller stall/flush/forward outputs.
// Optional STALL_CNT_EN adds the stall_cnt performance counter signal.
interface hazard_stall_ctrl_if #(
    parameter int unsigned REG_W = 5
`ifdef STALL_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
);
    logic [REG_W-1:0] rsD, rtD, rsE, rtE;
    logic [REG_W-1:0] writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW;
    logic             memtoregE, memtoregM;
    logic             branchD, pcsrcD, jumpD;
    logic             div_opE, div_ready;
    logic             div_start, div_busy;
    logic             forwardAD, forwardBD;
    logic [1:0]       forwardAE, forwardBE;
    logic             stallF, stallD, stallE;
    logic             flushD, flushE, flushM;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    // Pipeline side: supplies hazard information, consumes stall/flush/forward controls
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        output branchD, pcsrcD, jumpD, div_opE, div_ready,
        input  div_start, div_busy, forwardAD, forwardBD, forwardAE, forwardBE,
        input  stallF, stallD, stallE, flushD, flushE, flushM
`ifdef STALL_CNT_EN
        ,
        input  stall_cnt
`endif
    );

    // Controller side
    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        input  branchD, pcsrcD, jumpD, div_opE, div_ready,
        output div_start, div_busy, forwardAD, forwardBD, forwardAE, forwardBE,
        output stallF, stallD, stallE, flushD, flushE, flushM
`ifdef STALL_CNT_EN
        ,
        output stall_cnt
`endif
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use / branch-compare stalls,
// taken-branch flush and a handshake FSM that freezes F/D/E during a multi-cycle divide.
// Define STALL_CNT_EN to add a saturating count of stallF cycles (stall_cnt).
module hazard_stall_ctrl #(
    parameter int unsigned REG_W = 5
`ifdef STALL_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e r_state, w_state_nxt;
    logic       w_lwstall, w_brstall, w_divstall, w_stall;
    logic       w_flushE, w_div_start;
    logic [1:0] w_fwd_ae, w_fwd_be;

    // Register 0 is hardwired, so it never produces a dependency
    function automatic logic f_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Execute-stage forwarding: M-stage result takes priority over W-stage result
    always_comb begin
        w_fwd_ae = 2'b00;
        w_fwd_be = 2'b00;
        if (hz.regwriteM && f_hit(hz.writeregM, hz.rsE))      w_fwd_ae = 2'b10;
        else if (hz.regwriteW && f_hit(hz.writeregW, hz.rsE)) w_fwd_ae = 2'b01;
        if (hz.regwriteM && f_hit(hz.writeregM, hz.rtE))      w_fwd_be = 2'b10;
        else if (hz.regwriteW && f_hit(hz.writeregW, hz.rtE)) w_fwd_be = 2'b01;
    end

    // Hazard detection and the combined stall/flush controls
    always_comb begin
        w_lwstall  = hz.memtoregE && (f_hit(hz.rtE, hz.rsD) || f_hit(hz.rtE, hz.rtD));
        w_brstall  = hz.branchD &&
                     ((hz.regwriteE && (f_hit(hz.writeregE, hz.rsD) ||
                                        f_hit(hz.writeregE, hz.rtD))) ||
                      (hz.memtoregM && (f_hit(hz.writeregM, hz.rsD) ||
                                        f_hit(hz.writeregM, hz.rtD))));
        // Divide holds E from the issue cycle until the quotient arrives
        w_divstall = ((r_state == StIdle) && hz.div_opE) || (r_state == StBusy);
        w_stall    = w_lwstall || w_brstall || w_divstall;
        // A frozen E cannot take a bubble; the hazard is re-evaluated once the divide ends
        w_flushE   = (w_lwstall || w_brstall) && !w_divstall;
    end

    // Divider handshake next-state and start pulse
    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        case (r_state)
            StIdle: begin
                if (hz.div_opE && !w_flushE) begin
                    w_div_start = 1'b1;
                    w_state_nxt = StBusy;
                end
            end
            StBusy: begin
                if (hz.div_ready) w_state_nxt = StDone;
            end
            // E captures the quotient this cycle; the same div_opE must not restart
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_nxt;
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk) begin
        if (rst)                       r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign hz.stall_cnt = r_stall_cnt;
`endif

    assign hz.forwardAE = w_fwd_ae;
    assign hz.forwardBE = w_fwd_be;
    assign hz.forwardAD = hz.regwriteM && f_hit(hz.writeregM, hz.rsD);
    assign hz.forwardBD = hz.regwriteM && f_hit(hz.writeregM, hz.rtD);
    assign hz.stallF    = w_stall;
    assign hz.stallD    = w_stall;
    assign hz.stallE    = w_divstall;
    assign hz.flushE    = w_flushE;
    assign hz.flushM    = w_divstall;
    assign hz.flushD    = (hz.pcsrcD || hz.jumpD) && !w_stall;
    assign hz.div_start = w_div_start;
    assign hz.div_busy  = (r_state != StIdle);
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios followed by random traffic,
// expected outputs computed by a behavioural model and checked by an independent monitor.
module tb_hazard_stall_ctrl;
    localparam int unsigned REG_W = 5;
`ifdef STALL_CNT_EN
    localparam int unsigned CNT_W = 32;
`endif

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic rwE, rwM, rwW, mE, mM, brD, pcD, jD, divop, divrdy, rst;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef STALL_CNT_EN
    hazard_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();
    hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));
`else
    hazard_stall_ctrl_if #(.REG_W(REG_W)) hz ();
    hazard_stall_ctrl #(.REG_W(REG_W)) dut (.clk(clk), .rst(rst), .hz(hz));
`endif

    // Output vector: {fAE[1:0], fBE[1:0], fAD, fBD, stF, stD, stE, flD, flE, flM, start, busy}
    logic [13:0] exp_q[$];
    string       tag_q[$];
`ifdef STALL_CNT_EN
    longint      cnt_q[$];
`endif
    int n_checks = 0;
    int n_pass   = 0;

    // Model: a divide is either in flight, or in its single result cycle, or absent
    bit     m_inflight = 0;
    bit     m_result   = 0;
    longint m_cnt      = 0;

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src, input stim_t s);
        if (s.rwM && hit(s.wM, src)) return 2'b10;
        if (s.rwW && hit(s.wW, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] model_outs(input stim_t s);
        bit issue, lw, br, dv, st, fe, fd;
        issue = s.divop && !m_inflight && !m_result;
        dv    = issue || m_inflight;
        lw    = s.mE && (hit(s.rtE, s.rsD) || hit(s.rtE, s.rtD));
        br    = s.brD && ((s.rwE && (hit(s.wE, s.rsD) || hit(s.wE, s.rtD))) ||
                          (s.mM && (hit(s.wM, s.rsD) || hit(s.wM, s.rtD))));
        st    = lw || br || dv;
        fe    = (lw || br) && !dv;
        fd    = (s.pcD || s.jD) && !st;
        return {fwd(s.rsE, s), fwd(s.rtE, s), logic'(s.rwM && hit(s.wM, s.rsD)),
                logic'(s.rwM && hit(s.wM, s.rtD)), logic'(st), logic'(st), logic'(dv),
                logic'(fd), logic'(fe), logic'(dv), logic'(issue),
                logic'(m_inflight || m_result)};
    endfunction

    // Advance the model across one clock edge with the stimulus that was applied
    task automatic model_edge(input stim_t s, input bit stall_f);
        if (s.rst) begin
            m_inflight = 0;
            m_result   = 0;
            m_cnt      = 0;
        end else begin
            if (stall_f && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_result) m_result = 0;
            else if (m_inflight) begin
                if (s.divrdy) begin
                    m_inflight = 0;
                    m_result   = 1;
                end
            end else if (s.divop) m_inflight = 1;
        end
    endtask

    task automatic apply(input stim_t s);
        hz.rsD = s.rsD; hz.rtD = s.rtD; hz.rsE = s.rsE; hz.rtE = s.rtE;
        hz.writeregE = s.wE; hz.writeregM = s.wM; hz.writeregW = s.wW;
        hz.regwriteE = s.rwE; hz.regwriteM = s.rwM; hz.regwriteW = s.rwW;
        hz.memtoregE = s.mE; hz.memtoregM = s.mM;
        hz.branchD = s.brD; hz.pcsrcD = s.pcD; hz.jumpD = s.jD;
        hz.div_opE = s.divop; hz.div_ready = s.divrdy;
        rst = s.rst;
    endtask

    // One cycle: apply inputs after an edge, queue expectations, then cross the next edge
    task automatic step(input stim_t s, input string tag);
        logic [13:0] e;
        apply(s);
        e = model_outs(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
`ifdef STALL_CNT_EN
        cnt_q.push_back(m_cnt);
`endif
        @(posedge clk);
        model_edge(s, e[7]);
        #1;
    endtask

    // Monitor: compare DUT outputs against queued expectations mid-cycle
    initial begin
        logic [13:0] got, e;
        string       t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                got = {hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD, hz.stallF,
                       hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM, hz.div_start,
                       hz.div_busy};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL %s: outputs got %b expected %b", t, got, e);
`ifdef STALL_CNT_EN
                begin
                    longint ec;
                    ec = cnt_q.pop_front();
                    n_checks++;
                    if (hz.stall_cnt === CNT_W'(ec)) n_pass++;
                    else $display("FAIL %s stall_cnt: got %0d expected %0d", t, hz.stall_cnt, ec);
                end
`endif
            end
        end
    end

    initial begin
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        apply(s);
        repeat (2) @(posedge clk);
        #1;
        step(s, "reset");
        s.rst = 1'b0;
        step(s, "idle");

        // Load-use: lw r8 in E, r8 read in D
        s = '0; s.mE = 1; s.rtE = 8; s.rsD = 8;
        step(s, "loaduse");
        s = '0;
        step(s, "loaduse_clear");

        // Forwarding priority M over W, then W alone
        s = '0; s.rwM = 1; s.wM = 5; s.rwW = 1; s.wW = 5; s.rsE = 5; s.rtE = 5;
        step(s, "fwd_m_over_w");
        s.wM = 0;
        step(s, "fwd_w");

        // Register 0 never matches
        s = '0; s.wE = 0; s.rsD = 0; s.brD = 1; s.rwE = 1; s.rsE = 0; s.rwM = 1;
        step(s, "reg0");

        // Branch compare hazard on E producer and on M load
        s = '0; s.brD = 1; s.rwE = 1; s.wE = 4; s.rtD = 4;
        step(s, "brstall_e");
        s = '0; s.brD = 1; s.mM = 1; s.wM = 6; s.rsD = 6; s.rwM = 1;
        step(s, "brstall_m");

        // Divide: issue, 32 busy cycles, done, idle
        s = '0; s.divop = 1;
        step(s, "div_issue");
        for (int i = 0; i < 31; i++) step(s, "div_busy");
        s.divrdy = 1;
        step(s, "div_ready");
        s.divrdy = 0;
        step(s, "div_done");
        s = '0;
        step(s, "div_idle");

        // Divide with simultaneous load-use: divide dominates, load-use re-evaluated after
        s = '0; s.divop = 1; s.mE = 1; s.rtE = 2; s.rsD = 2;
        step(s, "div_lw_issue");
        step(s, "div_lw_busy");
        s.divrdy = 1;
        step(s, "div_lw_ready");
        s.divrdy = 0;
        step(s, "div_lw_done");

        // Taken branch during a stall is not flushed; flushed once the stall clears
        s = '0; s.mE = 1; s.rtE = 3; s.rsD = 3; s.pcD = 1;
        step(s, "flushD_stalled");
        s = '0; s.pcD = 1;
        step(s, "flushD_taken");
        s = '0; s.jD = 1;
        step(s, "flushD_jump");

        // Reset while busy; a later stray div_ready is ignored
        s = '0; s.divop = 1;
        step(s, "rst_div_issue");
        step(s, "rst_div_busy");
        s.rst = 1;
        step(s, "rst_assert");
        s = '0;
        step(s, "rst_after");
        s.divrdy = 1;
        step(s, "rst_stray_ready");
        s.divrdy = 0;
        step(s, "rst_idle");

        // Random traffic with small register indices to provoke matches
        for (int i = 0; i < 600; i++) begin
            s.rsD = 5'($urandom_range(0, 7)); s.rtD = 5'($urandom_range(0, 7));
            s.rsE = 5'($urandom_range(0, 7)); s.rtE = 5'($urandom_range(0, 7));
            s.wE  = 5'($urandom_range(0, 7)); s.wM  = 5'($urandom_range(0, 7));
            s.wW  = 5'($urandom_range(0, 7));
            s.rwE = 1'($urandom); s.rwM = 1'($urandom); s.rwW = 1'($urandom);
            s.mE  = ($urandom_range(0, 3) == 0); s.mM = ($urandom_range(0, 3) == 0);
            s.brD = ($urandom_range(0, 2) == 0); s.pcD = ($urandom_range(0, 3) == 0);
            s.jD  = ($urandom_range(0, 7) == 0);
            s.divop  = ($urandom_range(0, 9) == 0);
            s.divrdy = ($urandom_range(0, 5) == 0);
            s.rst    = ($urandom_range(0, 59) == 0);
            step(s, "random");
        end

        s = '0;
        step(s, "final");
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending got %0d expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
